inst_fetch_unit: RTL

//  Instruction fetch stage feeding the instruction decoder of the RV32I core.

---
 rtl/inst_fetch_unit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/inst_fetch_unit.sv
// RV32I instruction fetch stage: owns the fetch PC, issues word requests, buffers returned words.
// Define FETCH_MISALIGN_CHK_EN to flag redirects whose target has nonzero bits [1:0].
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        misalign_err_o
);

    localparam int unsigned IdxW = $clog2(BUF_DEPTH);
    localparam int unsigned PtrW = IdxW + 1;
    localparam logic [PtrW-1:0] Depth = PtrW'(BUF_DEPTH);
    localparam logic [PtrW-1:0] One   = PtrW'(1);

    typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    // Slot pointers with a wrap bit: head = oldest slot, fill = next to fill, tail = next to reserve.
    logic [PtrW-1:0] head_q, head_d, fill_q, fill_d, tail_q, tail_d;
    logic [PtrW-1:0] drop_cnt_q, drop_cnt_d;
    logic [31:0]     pc_mem   [BUF_DEPTH];
    logic [31:0]     data_mem [BUF_DEPTH];

    logic [PtrW-1:0] used, outstanding, drop_total;
    logic            redirect, req_fire, rsp_fill, inst_fire;

    assign used        = tail_q - head_q;
    assign outstanding = tail_q - fill_q;
    assign drop_total  = drop_cnt_q + outstanding;
    assign redirect    = redirect_valid_i && (state_q != StIdle);
    assign req_fire    = imem_req_valid_o && imem_req_ready_i;
    assign rsp_fill    = imem_rsp_valid_i && !redirect && (drop_cnt_q == '0) && (outstanding != '0);
    assign inst_fire   = inst_valid_o && inst_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  state_d = StRun;
            StRun:   if (redirect && (drop_cnt_d != '0)) state_d = StFlush;
            StFlush: if (drop_cnt_d == '0) state_d = StRun;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        imem_req_valid_o = (state_q == StRun) && (used < Depth) && !redirect_valid_i;
        imem_req_addr_o  = fetch_pc_q;
        inst_valid_o     = (fill_q != head_q);
        inst_o           = inst_valid_o ? data_mem[head_q[IdxW-1:0]] : '0;
        inst_pc_o        = inst_valid_o ? pc_mem[head_q[IdxW-1:0]] : '0;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        fill_d     = fill_q;
        tail_d     = tail_q;
        drop_cnt_d = drop_cnt_q;
        if (redirect) begin
            fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
            head_d     = tail_q;
            fill_d     = tail_q;
            // Everything in flight becomes stale; a response arriving now is dropped immediately.
            drop_cnt_d = (imem_rsp_valid_i && (drop_total != '0)) ? drop_total - One : drop_total;
        end else begin
            if (req_fire) begin
                tail_d     = tail_q + One;
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (imem_rsp_valid_i && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - One;
            end
            if (rsp_fill) begin
                fill_d = fill_q + One;
            end
            if (inst_fire) begin
                head_d = head_q + One;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= {RESET_PC[31:2], 2'b00};
            head_q     <= '0;
            fill_q     <= '0;
            tail_q     <= '0;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            fill_q     <= fill_d;
            tail_q     <= tail_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            pc_mem[tail_q[IdxW-1:0]] <= fetch_pc_q;
        end
        if (rsp_fill) begin
            data_mem[fill_q[IdxW-1:0]] <= imem_rsp_data_i;
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    logic misalign_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= redirect && (redirect_pc_i[1:0] != 2'b00);
        end
    end

    assign misalign_err_o = misalign_q;
`else
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^redirect_pc_i[1:0];
    assign misalign_err_o = 1'b0;
`endif

endmodule
